ps2_rx: RTL and testbench

- Upstream stage of the keyboard path. Deserialises raw PS/2 device-to-host frames (start, 8 data bits LSB first, odd parity, stop) from the keyboard pins.
- Emits one validated scan-code byte per frame, with a single-cycle strobe, into the user-input event stage (key data / key data enable pair).
- Runs entirely in the ps2_clk_i system domain. The PS/2 line clock is treated as asynchronous data and is oversampled.
- Host-to-device transmission is out of scope. The line pins are inputs only.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 78 +++++++
 rtl/ps2_rx.sv | 143 ++++++++++++++
 tb/tb_ps2_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive path.
//   - ps2_state_e          : frame deserialiser FSM states
//   - PS2_FRAME_DATA_BITS  : data bits carried by one PS/2 frame
//   - PS2_SC_BREAK/EXTENDED: scan-code prefixes also used by the event stage
//   - ps2_frame_ok()       : stop/parity acceptance rule for a finished frame
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_FRAME_DATA_BITS = 8;

  localparam logic [7:0] PS2_SC_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_SC_EXTENDED = 8'hE0;

  // A frame is accepted when the stop bit is high and byte+parity carry an
  // odd number of ones (odd parity).
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_DATA_BITS-1:0] data,
                                        input logic                           parity,
                                        input logic                           stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS/2 pins into the system clock domain and
// detects falling edges of the line clock.
//   clk_i            system clock
//   rst_i            synchronous active-high reset (all flops to idle level 1)
//   line_clk_i       raw PS/2 clock pin (asynchronous)
//   line_data_i      raw PS/2 data pin (asynchronous)
//   clk_fall_o       one-cycle pulse: line clock fell (synced/filtered level)
//   data_s_o         synchronised data line
// Optional macro PS2_RX_GLITCH_FILTER_EN inserts a FILTER_LEN-sample
// persistence filter on the synced line clock ahead of edge detection.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_clk_i,
  input  logic line_data_i,
  output logic clk_fall_o,
  output logic data_s_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_level;
  logic                   clk_level_prev_q;

  // Plain shift-register synchronisers; index 0 is closest to the pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], line_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], line_data_i};
    end
  end

`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  logic              filt_q;
  logic [FCNT_W-1:0] filt_cnt_q;

  // The filtered level flips only once FILTER_LEN consecutive samples have
  // disagreed with it; any agreeing sample restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_sync_q[SYNC_STAGES-1] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FCNT_LAST) begin
      filt_q     <= clk_sync_q[SYNC_STAGES-1];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign clk_level = filt_q;
`else
  assign clk_level = clk_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_level_prev_q <= 1'b1;
    end else begin
      clk_level_prev_q <= clk_level;
    end
  end

  assign clk_fall_o = clk_level_prev_q & ~clk_level;
  assign data_s_o   = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver (start, 8 data LSB first, odd
// parity, stop). Emits one validated scan-code byte per frame.
//   ps2_clk_i          system clock, all logic on rising edge
//   rst_i              synchronous active-high reset
//   ps2_line_clk_i     raw PS/2 clock pin (asynchronous, oversampled)
//   ps2_line_data_i    raw PS/2 data pin (asynchronous)
//   ps2_key_data_o     last good scan-code byte
//   ps2_key_data_en_o  one-cycle strobe: ps2_key_data_o updated this cycle
//   frame_err_o        one-cycle strobe: frame dropped (start/parity/stop/timeout)
// Optional macro PS2_RX_GLITCH_FILTER_EN enables the line-clock glitch filter
// (FILTER_LEN samples) inside ps2_line_sync.
//
// Handshake: the output side is valid-only. ps2_key_data_en_o marks a new
// byte for exactly one cycle and there is no ready/backpressure; the consumer
// must accept the byte in that cycle. frame_err_o is never high together with
// ps2_key_data_en_o.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       ps2_clk_i,
  input  logic       rst_i,
  input  logic       ps2_line_clk_i,
  input  logic       ps2_line_data_i,
  output logic [7:0] ps2_key_data_o,
  output logic       ps2_key_data_en_o,
  output logic       frame_err_o
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ps2_rx: SYNC_STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("ps2_rx: FILTER_LEN must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ps2_rx: TIMEOUT_CYCLES must be at least 2");
  end

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;
  localparam int BC_W = $clog2(PS2_FRAME_DATA_BITS);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(PS2_FRAME_DATA_BITS - 1);

  logic clk_fall;
  logic data_s;

  ps2_line_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_line_sync (
    .clk_i       (ps2_clk_i),
    .rst_i       (rst_i),
    .line_clk_i  (ps2_line_clk_i),
    .line_data_i (ps2_line_data_i),
    .clk_fall_o  (clk_fall),
    .data_s_o    (data_s)
  );

  ps2_state_e                     state_q;
  logic [BC_W-1:0]                bit_cnt_q;
  logic [PS2_FRAME_DATA_BITS-1:0] shift_q;
  logic                           parity_q;
  logic [TO_W-1:0]                timeout_q;
  logic [7:0]                     key_data_q;
  logic                           key_en_q;
  logic                           frame_err_q;

  // Frame deserialiser. Strobes default low every cycle so each is a single
  // registered pulse. A line-clock edge takes priority over the timeout.
  always_ff @(posedge ps2_clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      timeout_q   <= '0;
      key_data_q  <= 8'h00;
      key_en_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      key_en_q    <= 1'b0;
      frame_err_q <= 1'b0;

      if (clk_fall) begin
        timeout_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!data_s) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          ST_DATA: begin
            // LSB arrives first: enter at the top and shift right.
            shift_q   <= {data_s, shift_q[PS2_FRAME_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BC_LAST) begin
              state_q <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_q <= data_s;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            if (ps2_frame_ok(shift_q, parity_q, data_s)) begin
              key_data_q <= shift_q;
              key_en_q   <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q == ST_IDLE) begin
        timeout_q <= '0;
      end else if (timeout_q == TO_LAST) begin
        // Stalled frame: drop the partial byte and report it.
        state_q     <= ST_IDLE;
        bit_cnt_q   <= '0;
        shift_q     <= '0;
        timeout_q   <= '0;
        frame_err_q <= 1'b1;
      end else if (timeout_q != TO_MAX) begin
        timeout_q <= timeout_q + 1'b1;
      end
    end
  end

  assign ps2_key_data_o    = key_data_q;
  assign ps2_key_data_en_o = key_en_q;
  assign frame_err_o       = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed + randomised frames against a frame-level reference
// model (expected byte queue and expected error count).
module tb_ps2_rx;

  localparam int SYNC    = 2;
  localparam int TO      = 300;
  localparam int FL      = 4;
  localparam int HALF    = 12;
`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int EXP_LAT = SYNC + 1 + FL;
`else
  localparam int EXP_LAT = SYNC + 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lclk = 1'b1;
  logic ldata = 1'b1;
  logic [7:0] key;
  logic en;
  logic err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_rx #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .ps2_clk_i         (clk),
    .rst_i             (rst),
    .ps2_line_clk_i    (lclk),
    .ps2_line_data_i   (ldata),
    .ps2_key_data_o    (key),
    .ps2_key_data_en_o (en),
    .frame_err_o       (err)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int err_cnt = 0;
  int exp_err = 0;
  int en_cyc = 0;
  int fall_cyc = 0;
  logic [7:0] last_good = 8'h00;
  logic prev_en = 1'b0;
  logic prev_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: collect strobed bytes and error pulses; strobes must be
  // mutually exclusive and single-cycle.
  always @(negedge clk) begin
    if (en || err) begin
      chk("strobe_excl_single", {29'd0, en & err, en & prev_en, err & prev_err}, 32'd0);
    end
    if (en) begin
      obs_q.push_back(key);
      en_cyc = cyc;
    end
    if (err) err_cnt++;
    prev_en  = en;
    prev_err = err;
  end

  // ---------------- reference model ----------------
  // Frame in transmit order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    logic par;
    par = (($countones(b) % 2) == 0);
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = par ^ bad_par;
    f[10]   = 1'b1;
    return f;
  endfunction

  task automatic expect_frame(input logic [7:0] b, input bit bad_par);
    if (!bad_par) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_err++;
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_err"}, err_cnt, exp_err);
  endtask

  // ---------------- driver ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit: data changes mid high phase, optional 1-cycle low glitch on the
  // line clock, then the real falling edge and a low half period.
  task automatic send_bit(input logic b, input bit glitch);
    wait_cyc(3);
    ldata = b;
    wait_cyc(3);
    if (glitch) begin
      lclk = 1'b0;
      wait_cyc(1);
      lclk = 1'b1;
      wait_cyc(5);
    end else begin
      wait_cyc(6);
    end
    lclk = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    lclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
    logic [10:0] f;
    f = frame_bits(b, bad_par);
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
    ldata = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base_err;
    logic [7:0] rb;
    bit rbad;

    // Reset state
    rst = 1'b1;
    wait_cyc(4);
    chk("reset_key", {24'd0, key}, 32'h00);
    chk("reset_en", {31'd0, en}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    wait_cyc(10);

    // Single good frame 0x31 with latency check
    expect_frame(8'h31, 1'b0);
    send_frame(8'h31, 1'b0, 1'b0, 11);
    wait_cyc(10);
    chk("n_latency", en_cyc - fall_cyc, EXP_LAT);
    chk("n_key", {24'd0, key}, 32'h31);
    compare_stream("n_frame");

    // Back-to-back E0 F0 75
    expect_frame(8'hE0, 1'b0);
    expect_frame(8'hF0, 1'b0);
    expect_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    wait_cyc(10);
    compare_stream("b2b");

    // Parity error on 0x1C: key holds previous value
    expect_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    wait_cyc(10);
    compare_stream("parity");
    chk("parity_key_hold", {24'd0, key}, {24'd0, last_good});

    // Partial frame then timeout, followed by good 0x72
    exp_err++;
    send_frame(8'h5A, 1'b0, 1'b0, 5);
    wait_cyc(TO + 20);
    compare_stream("timeout");
    expect_frame(8'h72, 1'b0);
    send_frame(8'h72, 1'b0, 1'b0, 11);
    wait_cyc(10);
    compare_stream("after_timeout");

    // Reset in the middle of 0x6B, then 0x74
    send_frame(8'h6B, 1'b0, 1'b0, 7);
    wait_cyc(8);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(2);
    chk("midreset_key", {24'd0, key}, 32'h00);
    expect_frame(8'h74, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0, 11);
    wait_cyc(10);
    compare_stream("midreset");

    // Randomised back-to-back frames, ~25% with bad parity
    for (int i = 0; i < 8; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rbad = ($urandom_range(0, 3) == 0);
      expect_frame(rb, rbad);
      send_frame(rb, rbad, 1'b0, 11);
    end
    wait_cyc(10);
    compare_stream("random");
    chk("random_key", {24'd0, key}, {24'd0, last_good});

    // Glitches on the line clock during frame 0x75
`ifdef PS2_RX_GLITCH_FILTER_EN
    expect_frame(8'h75, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 11);
    wait_cyc(10);
    compare_stream("glitch_filtered");
`else
    base_err = err_cnt;
    send_frame(8'h75, 1'b0, 1'b1, 11);
    wait_cyc(TO + 20);
    chk("glitch_err_seen", {31'd0, err_cnt > base_err}, 32'd1);
    chk("glitch_no_byte", obs_q.size(), 32'd0);
    obs_q.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
